demux_buf: RTL and testbench

// - Buffered 1-to-2 demultiplexer: the inverse of the 2-input fetch-path mux.
// - Steers one valid/ready input stream to one of two output channels, chosen per beat by sel_i.
// - Each output channel has its own DEPTH-entry FIFO, so a stalled consumer does not block the other channel.
// - Sits between the fetch datapath and its two consumers, e.g. instruction queue vs. branch-target side channel.

---
 rtl/demux_fifo.sv | 66 ++++++
 rtl/demux_buf.sv | 71 +++++++
 tb/tb_demux_buf.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_fifo.sv
// demux_fifo: DEPTH-entry FIFO with count-derived full/empty; a push is visible at the head one cycle later.
// A push while full and a pop while empty are both dropped internally, so the caller never corrupts state.
module demux_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_dat,
   input  logic                       i_pop,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic [WIDTH-1:0]           o_head
);
   localparam int COUNT_W = $clog2(DEPTH+1);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [COUNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage is deliberately left unreset; the head is qualified by o_empty upstream.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_dat;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];

   a_count_range: assert property (@(posedge clk) disable iff (!reset_n) r_count <= FULL_CNT);
   a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n) o_full |-> !w_push);

endmodule

// File: rtl/demux_buf.sv
// demux_buf: steers one valid/ready stream into two independently buffered channels, 1-cycle push-to-output.
// ready_o depends only on sel_i and the selected FIFO's start-of-cycle full flag, so one stalled channel never blocks the other.
module demux_buf #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       valid_i,
   input  logic                       sel_i,
   input  logic [WIDTH-1:0]           d_i,
   output logic                       ready_o,
   output logic                       valid0_o,
   output logic [WIDTH-1:0]           d0_o,
   input  logic                       ready0_i,
   output logic [$clog2(DEPTH+1)-1:0] count0_o,
   output logic                       valid1_o,
   output logic [WIDTH-1:0]           d1_o,
   input  logic                       ready1_i,
   output logic [$clog2(DEPTH+1)-1:0] count1_o
);
   localparam int COUNT_W = $clog2(DEPTH+1);

   logic               w_full0;
   logic               w_full1;
   logic               w_empty0;
   logic               w_empty1;
   logic               w_push0;
   logic               w_push1;
   logic [WIDTH-1:0]   w_head0;
   logic [WIDTH-1:0]   w_head1;
   logic [COUNT_W-1:0] w_count0;
   logic [COUNT_W-1:0] w_count1;

   assign ready_o = sel_i ? ~w_full1 : ~w_full0;
   assign w_push0 = valid_i & ready_o & ~sel_i;
   assign w_push1 = valid_i & ready_o & sel_i;

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push0),
      .i_dat   (d_i),
      .i_pop   (ready0_i),
      .o_full  (w_full0),
      .o_empty (w_empty0),
      .o_count (w_count0),
      .o_head  (w_head0)
   );

   demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push1),
      .i_dat   (d_i),
      .i_pop   (ready1_i),
      .o_full  (w_full1),
      .o_empty (w_empty1),
      .o_count (w_count1),
      .o_head  (w_head1)
   );

   // Zero-gate heads so unwritten storage never leaks onto an idle channel.
   assign valid0_o = ~w_empty0;
   assign valid1_o = ~w_empty1;
   assign d0_o     = valid0_o ? w_head0 : '0;
   assign d1_o     = valid1_o ? w_head1 : '0;
   assign count0_o = w_count0;
   assign count1_o = w_count1;

endmodule

// File: tb/tb_demux_buf.sv
// Bench for demux_buf: directed vector table, stall/reset sequences, then constrained-random traffic vs. queue model.
module tb_demux_buf;
   localparam int WIDTH = 10;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             valid_i = 1'b0;
   logic             sel_i = 1'b0;
   logic [WIDTH-1:0] d_i = '0;
   logic             ready0_i = 1'b0;
   logic             ready1_i = 1'b0;
   logic             ready_o;
   logic             valid0_o;
   logic             valid1_o;
   logic [WIDTH-1:0] d0_o;
   logic [WIDTH-1:0] d1_o;
   logic [CW-1:0]    count0_o;
   logic [CW-1:0]    count1_o;

   demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .valid_i  (valid_i),
      .sel_i    (sel_i),
      .d_i      (d_i),
      .ready_o  (ready_o),
      .valid0_o (valid0_o),
      .d0_o     (d0_o),
      .ready0_i (ready0_i),
      .count0_o (count0_o),
      .valid1_o (valid1_o),
      .d1_o     (d1_o),
      .ready1_i (ready1_i),
      .count1_o (count1_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   bit m_acc = 1'b1;

   typedef struct {
      logic v; logic s; logic [WIDTH-1:0] d; logic r0; logic r1;
      logic rdy; logic v0; logic [WIDTH-1:0] d0; logic [CW-1:0] c0;
      logic v1; logic [WIDTH-1:0] d1; logic [CW-1:0] c1;
   } vec_t;
   vec_t vecs[14];

   function automatic vec_t mk(logic v, logic s, logic [WIDTH-1:0] d, logic r0, logic r1,
                               logic rdy, logic v0, logic [WIDTH-1:0] d0, logic [CW-1:0] c0,
                               logic v1, logic [WIDTH-1:0] d1, logic [CW-1:0] c1);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
      t.rdy = rdy; t.v0 = v0; t.d0 = d0; t.c0 = c0; t.v1 = v1; t.d1 = d1; t.c1 = c1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1);
      valid_i = v; sel_i = s; d_i = d; ready0_i = r0; ready1_i = r1;
      #1;
   endtask

   task automatic model_check(input string tag);
      logic exp_rdy;
      exp_rdy = sel_i ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk({tag, ".ready_o"},  32'(ready_o),  32'(exp_rdy));
      chk({tag, ".valid0_o"}, 32'(valid0_o), 32'(q0.size() != 0));
      chk({tag, ".d0_o"},     32'(d0_o),     (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
      chk({tag, ".count0_o"}, 32'(count0_o), 32'(q0.size()));
      chk({tag, ".valid1_o"}, 32'(valid1_o), 32'(q1.size() != 0));
      chk({tag, ".d1_o"},     32'(d1_o),     (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
      chk({tag, ".count1_o"}, 32'(count1_o), 32'(q1.size()));
   endtask

   // Model update uses the pre-edge inputs and model occupancy, mirroring the protocol rules.
   task automatic advance();
      bit p0, p1, rdy;
      p0  = ready0_i && (q0.size() != 0);
      p1  = ready1_i && (q1.size() != 0);
      rdy = sel_i ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      m_acc = valid_i && rdy;
      @(posedge clk);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (m_acc) begin
         if (sel_i) q1.push_back(d_i);
         else       q0.push_back(d_i);
      end
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".ready_o"},  32'(ready_o),  32'd1);
      chk({tag, ".valid0_o"}, 32'(valid0_o), 32'd0);
      chk({tag, ".valid1_o"}, 32'(valid1_o), 32'd0);
      chk({tag, ".d0_o"},     32'(d0_o),     32'd0);
      chk({tag, ".d1_o"},     32'(d1_o),     32'd0);
      chk({tag, ".count0_o"}, 32'(count0_o), 32'd0);
      chk({tag, ".count1_o"}, 32'(count1_o), 32'd0);
   endtask

   initial begin
      logic             pv, ps, r0, r1;
      logic [WIDTH-1:0] pd;
      int               thr0, thr1;

      vecs[0]  = mk(1,0,10'h0A5,1,1, 1, 0,10'h000,0, 0,10'h000,0);
      vecs[1]  = mk(1,1,10'h15A,1,1, 1, 1,10'h0A5,1, 0,10'h000,0);
      vecs[2]  = mk(0,0,10'h000,1,1, 1, 0,10'h000,0, 1,10'h15A,1);
      vecs[3]  = mk(0,0,10'h000,1,1, 1, 0,10'h000,0, 0,10'h000,0);
      vecs[4]  = mk(1,0,10'h001,0,1, 1, 0,10'h000,0, 0,10'h000,0);
      vecs[5]  = mk(1,0,10'h002,0,1, 1, 1,10'h001,1, 0,10'h000,0);
      vecs[6]  = mk(1,0,10'h003,0,1, 1, 1,10'h001,2, 0,10'h000,0);
      vecs[7]  = mk(1,0,10'h004,0,1, 1, 1,10'h001,3, 0,10'h000,0);
      vecs[8]  = mk(1,0,10'h005,0,1, 0, 1,10'h001,4, 0,10'h000,0);
      vecs[9]  = mk(1,1,10'h200,0,0, 1, 1,10'h001,4, 0,10'h000,0);
      vecs[10] = mk(1,0,10'h005,0,0, 0, 1,10'h001,4, 1,10'h200,1);
      vecs[11] = mk(1,0,10'h005,1,0, 0, 1,10'h001,4, 1,10'h200,1);
      vecs[12] = mk(1,0,10'h005,0,0, 1, 1,10'h002,3, 1,10'h200,1);
      vecs[13] = mk(0,0,10'h000,0,0, 0, 1,10'h002,4, 1,10'h200,1);

      #1;
      chk_idle("reset");
      sel_i = 1'b1;
      #1;
      chk("reset.ready_sel1", 32'(ready_o), 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
         chk($sformatf("vec%0d.ready_o", i),  32'(ready_o),  32'(vecs[i].rdy));
         chk($sformatf("vec%0d.valid0_o", i), 32'(valid0_o), 32'(vecs[i].v0));
         chk($sformatf("vec%0d.d0_o", i),     32'(d0_o),     32'(vecs[i].d0));
         chk($sformatf("vec%0d.count0_o", i), 32'(count0_o), 32'(vecs[i].c0));
         chk($sformatf("vec%0d.valid1_o", i), 32'(valid1_o), 32'(vecs[i].v1));
         chk($sformatf("vec%0d.d1_o", i),     32'(d1_o),     32'(vecs[i].d1));
         chk($sformatf("vec%0d.count1_o", i), 32'(count1_o), 32'(vecs[i].c1));
         advance();
      end

      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 10'h3FF, 0, 0);
         chk("stall.valid1_o", 32'(valid1_o), 32'd1);
         chk("stall.d1_o",     32'(d1_o),     32'h200);
         chk("stall.count1_o", 32'(count1_o), 32'd1);
         advance();
      end
      drive(0, 0, 10'h000, 0, 1);
      chk("release.d1_o", 32'(d1_o), 32'h200);
      advance();
      drive(0, 0, 10'h000, 0, 0);
      chk("release.valid1_o", 32'(valid1_o), 32'd0);
      chk("release.d1_o_zero", 32'(d1_o), 32'd0);

      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 10'h000, 1, 0);
         model_check("drain0");
         advance();
      end
      drive(0, 0, 10'h000, 0, 0);
      chk_idle("drained");

      drive(1, 0, 10'h3FF, 0, 0);
      advance();
      drive(1, 1, 10'h111, 0, 0);
      advance();
      drive(1, 1, 10'h222, 0, 0);
      chk("pre_rst.count0_o", 32'(count0_o), 32'd1);
      chk("pre_rst.count1_o", 32'(count1_o), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_idle("midrst");
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;
      chk_idle("midrst_hold");
      drive(0, 0, 10'h000, 0, 0);
      reset_n = 1'b1;
      #1;
      chk_idle("post_rst");

      pv = 1'b0; ps = 1'b0; pd = '0;
      m_acc = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         case ((i / 1000) % 5)
            0: begin thr0 = 20; thr1 = 80; end
            1: begin thr0 = 80; thr1 = 20; end
            2: begin thr0 = 50; thr1 = 50; end
            3: begin thr0 = 95; thr1 = 95; end
            default: begin thr0 = 10; thr1 = 10; end
         endcase
         if (!(pv && !m_acc)) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = 1'($urandom_range(0, 1));
            pd = 10'($urandom_range(0, 1023));
         end
         r0 = ($urandom_range(0, 99) < thr0);
         r1 = ($urandom_range(0, 99) < thr1);
         drive(pv, ps, pd, r0, r1);
         model_check("rand");
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
